// File: rtl/jtcop_mcu_pkg.sv
// Shared types and register layout for the main-CPU side of the i8751 MCU mailbox.
package jtcop_mcu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Register offsets within the MCU window (cpu_addr)
    localparam logic REG_DATA = 1'b0;
    localparam logic REG_CTRL = 1'b1;

    // CTRL write fields
    localparam int unsigned CTRL_SEL_LSB = 0;
    localparam int unsigned CTRL_SEL_W   = 3;
    localparam int unsigned CTRL_IRQEN   = 3;
    localparam int unsigned CTRL_CLR     = 4;

    // CTRL read (status) fields
    localparam int unsigned STAT_SEL_LSB = 0;
    localparam int unsigned STAT_IRQEN   = 3;
    localparam int unsigned STAT_BUSY    = 4;
    localparam int unsigned STAT_RSP     = 5;
    localparam int unsigned STAT_TMO     = 6;
    localparam int unsigned STAT_OVR     = 7;

    // Byte-lane merge for 68000 writes; dsn is active-low {UDS, LDS}
    function automatic logic [15:0] merge_bytes(input logic [15:0] old_w,
                                                input logic [15:0] wr_w,
                                                input logic [1:0]  dsn);
        logic [15:0] res;
        res = old_w;
        if (!dsn[1]) res[15:8] = wr_w[15:8];
        if (!dsn[0]) res[7:0]  = wr_w[7:0];
        return res;
    endfunction

endpackage

// File: rtl/jtcop_mcu_hostif_if.sv
// CPU bus and MCU link signals of the mailbox, grouped for port connection.
interface jtcop_mcu_hostif_if;
    logic        cs;
    logic        cpu_addr;
    logic        cpu_rnw;
    logic [1:0]  cpu_dsn;
    logic [15:0] cpu_dout;
    logic [15:0] cpu_din;
    logic [15:0] mcu_din;
    logic [5:0]  mcu_sel;
    logic [15:0] mcu_dout;
    logic        mcu_wstb;
    logic        nexirq;

    // Mailbox side
    modport slave (
        input  cs, cpu_addr, cpu_rnw, cpu_dsn, cpu_dout, mcu_dout, mcu_wstb,
        output cpu_din, mcu_din, mcu_sel, nexirq
    );

    // Driver side (CPU and MCU models)
    modport master (
        output cs, cpu_addr, cpu_rnw, cpu_dsn, cpu_dout, mcu_dout, mcu_wstb,
        input  cpu_din, mcu_din, mcu_sel, nexirq
    );
endinterface

// File: rtl/jtcop_mcu_pulse.sv
// Down-counter strobe stretcher: load starts a strobe lasting PULSE clocks.
module jtcop_mcu_pulse #(
    parameter int unsigned PULSE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic strobe_o,
    output logic done_c
);
    localparam int unsigned CW = (PULSE > 1) ? $clog2(PULSE) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    // Next count; done_c flags the last strobe cycle
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_c = busy_q && (cnt_q == '0);
        if (load_i) begin
            cnt_d  = CW'(PULSE - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) busy_d = 1'b0;
            else             cnt_d  = cnt_q - CW'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign strobe_o = busy_q;

endmodule

// File: rtl/jtcop_mcu_hostif.sv
// Main-CPU mailbox for the i8751 link: command latch, control register,
// stretched request strobe, reply capture with ready flag, IRQ and timeout.
module jtcop_mcu_hostif
    import jtcop_mcu_pkg::*;
#(
    parameter int unsigned PULSE = 16,
    parameter int unsigned TOW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    jtcop_mcu_hostif_if.slave bus
);
    state_e         state_q, state_d;
    logic           cs_q;
    logic [15:0]    din_q, din_d;
    logic [2:0]     sel_q, sel_d;
    logic           irq_en_q, irq_en_d;
    logic           rsp_q, rsp_d;
    logic           tmo_q, tmo_d;
    logic           ovr_q, ovr_d;
    logic [TOW-1:0] tcnt_q, tcnt_d;
    logic [15:0]    cpu_din_q, cpu_din_d;
    logic           nexirq_q, nexirq_d;

    logic           access_c, data_wr_c, data_rd_c, ctrl_wr_c, ctrl_rd_c;
    logic           pulse_load_c, pulse_done_c, pulse_strobe;
    logic [15:0]    status_c;

    // Request strobe stretcher
    jtcop_mcu_pulse #(.PULSE(PULSE)) u_pulse (
        .clk      (clk),
        .rst      (rst),
        .load_i   (pulse_load_c),
        .strobe_o (pulse_strobe),
        .done_c   (pulse_done_c)
    );

    // Bus access decode: act once on the rising edge of cs
    always_comb begin
        access_c  = bus.cs & ~cs_q;
        data_wr_c = access_c & ~bus.cpu_rnw & (bus.cpu_addr == REG_DATA);
        data_rd_c = access_c &  bus.cpu_rnw & (bus.cpu_addr == REG_DATA);
        ctrl_wr_c = access_c & ~bus.cpu_rnw & (bus.cpu_addr == REG_CTRL) & ~bus.cpu_dsn[0];
        ctrl_rd_c = access_c &  bus.cpu_rnw & (bus.cpu_addr == REG_CTRL);
    end

    // Status word returned on CTRL reads
    always_comb begin
        status_c = '0;
        status_c[STAT_SEL_LSB +: CTRL_SEL_W] = sel_q;
        status_c[STAT_IRQEN] = irq_en_q;
        status_c[STAT_BUSY]  = (state_q != ST_IDLE);
        status_c[STAT_RSP]   = rsp_q;
        status_c[STAT_TMO]   = tmo_q;
        status_c[STAT_OVR]   = ovr_q;
    end

    // Mailbox FSM and register next-state
    always_comb begin
        state_d      = state_q;
        din_d        = din_q;
        sel_d        = sel_q;
        irq_en_d     = irq_en_q;
        rsp_d        = rsp_q;
        tmo_d        = tmo_q;
        ovr_d        = ovr_q;
        tcnt_d       = tcnt_q;
        cpu_din_d    = cpu_din_q;
        pulse_load_c = 1'b0;

        // CTRL write: clear goes first so a timeout in the same cycle still lands
        if (ctrl_wr_c) begin
            sel_d    = bus.cpu_dout[CTRL_SEL_LSB +: CTRL_SEL_W];
            irq_en_d = bus.cpu_dout[CTRL_IRQEN];
            if (bus.cpu_dout[CTRL_CLR]) begin
                ovr_d = 1'b0;
                tmo_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (data_wr_c) begin
                    din_d        = merge_bytes(din_q, bus.cpu_dout, bus.cpu_dsn);
                    tmo_d        = 1'b0;
                    pulse_load_c = 1'b1;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (data_wr_c) ovr_d = 1'b1;
                if (pulse_done_c) begin
                    tcnt_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_wr_c) ovr_d = 1'b1;
                if (bus.mcu_wstb) begin
                    state_d = ST_IDLE;
                end else if (tcnt_q == '1) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TOW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Reply flag: an MCU write beats a simultaneous CPU read
        if (data_rd_c)    rsp_d = 1'b0;
        if (bus.mcu_wstb) rsp_d = 1'b1;

        if (data_rd_c)      cpu_din_d = bus.mcu_dout;
        else if (ctrl_rd_c) cpu_din_d = status_c;

        nexirq_d = ~(irq_en_d & rsp_d);
    end

    // State and register update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cs_q      <= 1'b0;
            din_q     <= '0;
            sel_q     <= '0;
            irq_en_q  <= 1'b0;
            rsp_q     <= 1'b0;
            tmo_q     <= 1'b0;
            ovr_q     <= 1'b0;
            tcnt_q    <= '0;
            cpu_din_q <= '0;
            nexirq_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cs_q      <= bus.cs;
            din_q     <= din_d;
            sel_q     <= sel_d;
            irq_en_q  <= irq_en_d;
            rsp_q     <= rsp_d;
            tmo_q     <= tmo_d;
            ovr_q     <= ovr_d;
            tcnt_q    <= tcnt_d;
            cpu_din_q <= cpu_din_d;
            nexirq_q  <= nexirq_d;
        end
    end

    assign bus.mcu_din = din_q;
    assign bus.mcu_sel = {sel_q, 2'b00, pulse_strobe};
    assign bus.cpu_din = cpu_din_q;
    assign bus.nexirq  = nexirq_q;

endmodule

// File: tb/tb_jtcop_mcu_hostif.sv
// Self-checking bench for jtcop_mcu_hostif with a cycle-indexed reference model.
module tb_jtcop_mcu_hostif;
    localparam int PULSE   = 16;
    localparam int TOW     = 4;
    localparam int TMO_CYC = 1 << TOW;
    localparam logic A_DATA = 1'b0;
    localparam logic A_CTRL = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    jtcop_mcu_hostif_if bus();

    jtcop_mcu_hostif #(.PULSE(PULSE), .TOW(TOW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: registers plus request timeline in absolute cycles
    logic [15:0] m_din, m_rd;
    logic [2:0]  m_sel;
    logic        m_irqen, m_rsp, m_tmo, m_ovr;
    bit          m_req_v, m_tmo_pend, m_prev_cs;
    int          m_req, m_end;

    function automatic logic [15:0] m_merge(input logic [15:0] old_w, input logic [15:0] wd,
                                            input logic [1:0] dsn);
        logic [15:0] r;
        r = old_w;
        if (!dsn[1]) r[15:8] = wd[15:8];
        if (!dsn[0]) r[7:0]  = wd[7:0];
        return r;
    endfunction

    function automatic bit m_busy(input int s);
        return m_req_v && (s >= m_req) && (s < m_end);
    endfunction

    function automatic logic [5:0] m_mcu_sel(input int s);
        logic strobe;
        strobe = m_req_v && (s >= m_req) && (s < m_req + PULSE);
        return {m_sel, 2'b00, strobe};
    endfunction

    function automatic logic [15:0] m_status(input int s);
        return {8'h00, m_ovr, m_tmo, m_rsp, m_busy(s), m_irqen, m_sel};
    endfunction

    function automatic logic m_nexirq();
        return ~(m_irqen & m_rsp);
    endfunction

    function automatic void m_resolve(input int s);
        if (m_req_v && m_tmo_pend && s >= m_end) begin
            m_tmo      = 1'b1;
            m_tmo_pend = 1'b0;
        end
    endfunction

    task automatic model_reset();
        m_din = '0; m_rd = '0; m_sel = '0;
        m_irqen = 0; m_rsp = 0; m_tmo = 0; m_ovr = 0;
        m_req_v = 0; m_tmo_pend = 0; m_prev_cs = 0;
        m_req = 0; m_end = 0;
    endtask

    // Drive one clock of bus/MCU activity, advance the model, sample #1 after the edge
    task automatic step(input bit acc, input logic addr, input logic rnw, input logic [1:0] dsn,
                        input logic [15:0] wd, input bit wstb, input logic [15:0] mdout);
        int e;
        bit rise, pre_busy, pre_wait;
        bus.cs = acc; bus.cpu_addr = addr; bus.cpu_rnw = rnw; bus.cpu_dsn = dsn;
        bus.cpu_dout = wd; bus.mcu_wstb = wstb; bus.mcu_dout = mdout;
        e = cyc + 1;
        rise = acc && !m_prev_cs;
        m_prev_cs = acc;
        m_resolve(e - 1);
        pre_busy = m_busy(e - 1);
        pre_wait = pre_busy && (e - 1 >= m_req + PULSE);
        if (rise && rnw) begin
            if (addr == A_CTRL) m_rd = m_status(e - 1);
            else begin
                m_rd  = mdout;
                m_rsp = 1'b0;
            end
        end
        if (rise && !rnw && addr == A_CTRL && !dsn[0]) begin
            m_sel   = wd[2:0];
            m_irqen = wd[3];
            if (wd[4]) begin m_ovr = 1'b0; m_tmo = 1'b0; end
        end
        if (rise && !rnw && addr == A_DATA) begin
            if (!pre_busy) begin
                m_din = m_merge(m_din, wd, dsn);
                m_tmo = 1'b0;
                m_req_v = 1; m_req = e; m_end = e + PULSE + TMO_CYC; m_tmo_pend = 1;
            end else begin
                m_ovr = 1'b1;
            end
        end
        if (wstb) begin
            m_rsp = 1'b1;
            if (pre_wait) begin m_end = e; m_tmo_pend = 0; end
        end
        m_resolve(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, A_DATA, 1'b1, 2'b11, 16'h0, 0, 16'h0);
    endtask

    task automatic do_reset();
        bus.cs = 0; bus.cpu_addr = 0; bus.cpu_rnw = 1; bus.cpu_dsn = 2'b11;
        bus.cpu_dout = '0; bus.mcu_dout = '0; bus.mcu_wstb = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.mcu_sel !== 6'h00) begin errors++; $display("FAIL reset_mcu_sel: got %h want 00", bus.mcu_sel); end
        checks++; if (bus.nexirq !== 1'b1) begin errors++; $display("FAIL reset_nexirq: got %b want 1", bus.nexirq); end
        checks++; if (bus.mcu_din !== 16'h0000) begin errors++; $display("FAIL reset_mcu_din: got %h want 0000", bus.mcu_din); end
        checks++; if (bus.cpu_din !== 16'h0000) begin errors++; $display("FAIL reset_cpu_din: got %h want 0000", bus.cpu_din); end
        step(1, A_CTRL, 1'b1, 2'b00, 16'h0, 0, 16'hDEAD);
        checks++; if (bus.cpu_din !== 16'h0000) begin errors++; $display("FAIL reset_ctrl_read: got %h want 0000", bus.cpu_din); end
        idle(1);
    endtask

    task automatic test_data_write();
        int hi;
        step(1, A_DATA, 1'b0, 2'b00, 16'hA55A, 0, 16'h0);
        checks++; if (bus.mcu_din !== 16'hA55A) begin errors++; $display("FAIL dw_mcu_din: got %h want a55a", bus.mcu_din); end
        hi = 0;
        while (bus.mcu_sel[0] === 1'b1 && hi < 4 * PULSE) begin hi++; idle(1); end
        checks++; if (hi != PULSE) begin errors++; $display("FAIL dw_pulse_len: got %0d want %0d", hi, PULSE); end
        step(1, A_CTRL, 1'b1, 2'b00, 16'h0, 0, 16'h0);
        checks++; if (bus.cpu_din[4] !== 1'b1) begin errors++; $display("FAIL dw_busy_wait: got %b want 1", bus.cpu_din[4]); end
        idle(1);
        step(0, A_DATA, 1'b1, 2'b11, 16'h0, 1, 16'h5678);
        idle(1);
        step(1, A_CTRL, 1'b1, 2'b00, 16'h0, 0, 16'h0);
        checks++; if (bus.cpu_din !== 16'h0020) begin errors++; $display("FAIL dw_status_after_rsp: got %h want 0020", bus.cpu_din); end
        idle(1);
        step(1, A_DATA, 1'b1, 2'b00, 16'h0, 0, 16'h5678);
        checks++; if (bus.cpu_din !== 16'h5678) begin errors++; $display("FAIL dw_data_read: got %h want 5678", bus.cpu_din); end
        idle(1);
    endtask

    task automatic test_irq();
        step(1, A_CTRL, 1'b0, 2'b00, 16'h000D, 0, 16'h0);
        checks++; if (bus.mcu_sel !== 6'b101000) begin errors++; $display("FAIL irq_mcu_sel: got %b want 101000", bus.mcu_sel); end
        checks++; if (bus.nexirq !== 1'b1) begin errors++; $display("FAIL irq_idle_nexirq: got %b want 1", bus.nexirq); end
        idle(1);
        step(0, A_DATA, 1'b1, 2'b11, 16'h0, 1, 16'h1234);
        checks++; if (bus.nexirq !== 1'b0) begin errors++; $display("FAIL irq_assert: got %b want 0", bus.nexirq); end
        idle(1);
        step(1, A_DATA, 1'b1, 2'b00, 16'h0, 0, 16'h1234);
        checks++; if (bus.cpu_din !== 16'h1234) begin errors++; $display("FAIL irq_data_read: got %h want 1234", bus.cpu_din); end
        checks++; if (bus.nexirq !== 1'b1) begin errors++; $display("FAIL irq_release: got %b want 1", bus.nexirq); end
        idle(1);
    endtask

    task automatic test_bytes_ovr();
        step(1, A_DATA, 1'b0, 2'b00, 16'hA55A, 0, 16'h0);
        idle(PULSE + 1);
        step(0, A_DATA, 1'b1, 2'b11, 16'h0, 1, 16'h0);
        idle(1);
        step(1, A_DATA, 1'b0, 2'b10, 16'hFF77, 0, 16'h0);
        checks++; if (bus.mcu_din !== 16'hA577) begin errors++; $display("FAIL byte_lane: got %h want a577", bus.mcu_din); end
        idle(2);
        step(1, A_DATA, 1'b0, 2'b00, 16'h0000, 0, 16'h0);
        checks++; if (bus.mcu_din !== 16'hA577) begin errors++; $display("FAIL ovr_dropped: got %h want a577", bus.mcu_din); end
        idle(1);
        step(1, A_CTRL, 1'b1, 2'b00, 16'h0, 0, 16'h0);
        checks++; if (bus.cpu_din[7] !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", bus.cpu_din[7]); end
        idle(1);
        step(1, A_CTRL, 1'b0, 2'b00, 16'h0010, 0, 16'h0);
        idle(1);
        step(1, A_CTRL, 1'b1, 2'b00, 16'h0, 0, 16'h0);
        checks++; if (bus.cpu_din[7] !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", bus.cpu_din[7]); end
        idle(1);
    endtask

    task automatic test_timeout();
        int x, s;
        idle(PULSE + TMO_CYC + 2);
        for (int off = 0; off < 2; off++) begin
            step(1, A_CTRL, 1'b0, 2'b00, 16'h0010, 0, 16'h0);
            idle(1);
            step(1, A_DATA, 1'b0, 2'b00, 16'($urandom), 0, 16'h0);
            x = cyc + PULSE + TMO_CYC;
            while (cyc < x - 2 + off) idle(1);
            s = x - 2 + off;
            step(1, A_CTRL, 1'b1, 2'b00, 16'h0, 0, 16'h0);
            checks++; if (bus.cpu_din[4] !== 1'b1 || bus.cpu_din[6] !== 1'b0) begin
                errors++; $display("FAIL tmo_before_%0d: busy/tmo got %b%b want 10", s - x, bus.cpu_din[4], bus.cpu_din[6]); end
            idle(1);
            s = x + off;
            step(1, A_CTRL, 1'b1, 2'b00, 16'h0, 0, 16'h0);
            checks++; if (bus.cpu_din[4] !== 1'b0 || bus.cpu_din[6] !== 1'b1) begin
                errors++; $display("FAIL tmo_after_%0d: busy/tmo got %b%b want 01", s - x, bus.cpu_din[4], bus.cpu_din[6]); end
            checks++; if (bus.cpu_din !== m_rd) begin errors++; $display("FAIL tmo_status: got %h want %h", bus.cpu_din, m_rd); end
            idle(1);
        end
    endtask

    task automatic test_collide();
        step(1, A_DATA, 1'b1, 2'b00, 16'h0, 0, 16'h0);
        idle(1);
        step(1, A_DATA, 1'b1, 2'b00, 16'h0, 1, 16'hABCD);
        checks++; if (bus.cpu_din !== 16'hABCD) begin errors++; $display("FAIL collide_read: got %h want abcd", bus.cpu_din); end
        idle(1);
        step(1, A_CTRL, 1'b1, 2'b00, 16'h0, 0, 16'h0);
        checks++; if (bus.cpu_din[5] !== 1'b1) begin errors++; $display("FAIL collide_rsp: got %b want 1", bus.cpu_din[5]); end
        idle(1);
    endtask

    task automatic test_cs_held();
        int rises;
        logic prev;
        logic [15:0] first;
        idle(PULSE + TMO_CYC + 2);
        step(1, A_CTRL, 1'b0, 2'b00, 16'h0010, 0, 16'h0);
        idle(1);
        rises = 0;
        prev = bus.mcu_sel[0];
        first = 16'($urandom);
        for (int i = 0; i < 10; i++) begin
            step(1, A_DATA, 1'b0, 2'b00, (i == 0) ? first : 16'($urandom), 0, 16'h0);
            if (bus.mcu_sel[0] === 1'b1 && prev === 1'b0) rises++;
            prev = bus.mcu_sel[0];
        end
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (bus.mcu_sel[0] === 1'b1 && prev === 1'b0) rises++;
            prev = bus.mcu_sel[0];
        end
        checks++; if (rises != 1) begin errors++; $display("FAIL held_cs_pulses: got %0d want 1", rises); end
        checks++; if (bus.mcu_din !== first) begin errors++; $display("FAIL held_cs_din: got %h want %h", bus.mcu_din, first); end
        step(1, A_CTRL, 1'b1, 2'b00, 16'h0, 0, 16'h0);
        checks++; if (bus.cpu_din[7] !== 1'b0) begin errors++; $display("FAIL held_cs_ovr: got %b want 0", bus.cpu_din[7]); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        step(1, A_DATA, 1'b0, 2'b00, 16'h1111, 0, 16'h0);
        idle(PULSE);
        step(0, A_DATA, 1'b1, 2'b11, 16'h0, 1, 16'h0);
        step(1, A_DATA, 1'b0, 2'b00, 16'h2222, 0, 16'h0);
        checks++; if (bus.mcu_din !== 16'h2222) begin errors++; $display("FAIL b2b_accept_din: got %h want 2222", bus.mcu_din); end
        checks++; if (bus.mcu_sel[0] !== 1'b1) begin errors++; $display("FAIL b2b_accept_strobe: got %b want 1", bus.mcu_sel[0]); end
        idle(PULSE);
        step(1, A_DATA, 1'b0, 2'b00, 16'h3333, 1, 16'h0);
        checks++; if (bus.mcu_din !== 16'h2222) begin errors++; $display("FAIL b2b_same_cycle_drop: got %h want 2222", bus.mcu_din); end
        idle(1);
        step(1, A_DATA, 1'b0, 2'b00, 16'h4444, 0, 16'h0);
        checks++; if (bus.mcu_din !== 16'h4444) begin errors++; $display("FAIL b2b_next_accept: got %h want 4444", bus.mcu_din); end
        idle(1);
        step(1, A_CTRL, 1'b1, 2'b00, 16'h0, 0, 16'h0);
        checks++; if (bus.cpu_din[7] !== 1'b1) begin errors++; $display("FAIL b2b_ovr: got %b want 1", bus.cpu_din[7]); end
        idle(1);
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            step((r >= 4 && r <= 7), (r == 5 || r == 7), (r >= 6),
                 2'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0), 16'($urandom));
            checks++; if (bus.mcu_din !== m_din) begin errors++; $display("FAIL rnd_mcu_din@%0d: got %h want %h", cyc, bus.mcu_din, m_din); end
            checks++; if (bus.mcu_sel !== m_mcu_sel(cyc)) begin errors++; $display("FAIL rnd_mcu_sel@%0d: got %b want %b", cyc, bus.mcu_sel, m_mcu_sel(cyc)); end
            checks++; if (bus.nexirq !== m_nexirq()) begin errors++; $display("FAIL rnd_nexirq@%0d: got %b want %b", cyc, bus.nexirq, m_nexirq()); end
            checks++; if (bus.cpu_din !== m_rd) begin errors++; $display("FAIL rnd_cpu_din@%0d: got %h want %h", cyc, bus.cpu_din, m_rd); end
        end
    endtask

    task automatic test_reset_in_req();
        idle(PULSE + TMO_CYC + 2);
        step(1, A_DATA, 1'b0, 2'b00, 16'h9876, 0, 16'h0);
        idle(3);
        checks++; if (bus.mcu_sel[0] !== 1'b1) begin errors++; $display("FAIL rst_req_pre: got %b want 1", bus.mcu_sel[0]); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.mcu_sel[0] !== 1'b0) begin errors++; $display("FAIL rst_req_drop: got %b want 0", bus.mcu_sel[0]); end
        checks++; if (bus.mcu_din !== 16'h0000) begin errors++; $display("FAIL rst_req_din: got %h want 0000", bus.mcu_din); end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_irq();
        test_bytes_ovr();
        test_timeout();
        test_collide();
        test_cs_held();
        test_back_to_back();
        test_random();
        test_reset_in_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
